// File: rtl/eprobe_led_sequencer_pkg.sv
// eprobe_pkg: shared definitions for the probe LED sequencer.
//   - command op encodings carried on cmd_op
//   - sequencer state enum
//   - cnt_width(): width of the strobe timer counter for a given cycle count
package eprobe_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SINGLE = 2'b01;
  localparam logic [1:0] OP_RANGE  = 2'b10;
  localparam logic [1:0] OP_ALL    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_DONE
  } seq_state_t;

  // The timer holds values 0..max_cyc-1, so it needs clog2(max_cyc) bits,
  // with a floor of one bit so a 1-cycle phase still has a real register.
  function automatic int cnt_width(input int max_cyc);
    return (max_cyc < 2) ? 1 : $clog2(max_cyc);
  endfunction

endpackage

// File: rtl/eprobe_led_sequencer_if.sv
// eprobe_led_sequencer_if: host command channel of the probe LED sequencer.
//   cmd_valid / cmd_ready : valid/ready handshake
//   cmd_op                : NOP / SINGLE / RANGE / ALL
//   cmd_vled, cmd_en      : drive code and enable applied for the sequence
//   cmd_start, cmd_end    : first and last (inclusive) full LED address
// Modports: master = host command endpoint, slave = sequencer.
interface eprobe_led_sequencer_if #(
  parameter int AW     = 10,
  parameter int VLED_W = 3
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [VLED_W-1:0] cmd_vled;
  logic              cmd_en;
  logic [AW-1:0]     cmd_start;
  logic [AW-1:0]     cmd_end;

  modport master (
    output cmd_valid, cmd_op, cmd_vled, cmd_en, cmd_start, cmd_end,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_vled, cmd_en, cmd_start, cmd_end,
    output cmd_ready
  );

endinterface

// File: rtl/eprobe_led_sequencer_strobe_timer.sv
// eprobe_strobe_timer: loadable down-counter timing the SETUP and LOAD phases.
//   clk, rst   : clock, asynchronous active-high reset
//   reload     : load reload_val into the counter this cycle
//   reload_val : phase length minus one
//   tc         : high while the counter sits at zero (last cycle of a phase)
module eprobe_strobe_timer
  import eprobe_pkg::*;
#(
  parameter  int MAX_CYC = 1,
  localparam int CW      = cnt_width(MAX_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reload,
  input  logic [CW-1:0] reload_val,
  output logic          tc
);

  logic [CW-1:0] count;

  // Count down to zero and park there; a reload restarts the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (reload) begin
      count <= reload_val;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/eprobe_led_sequencer.sv
// eprobe_led_sequencer: walks probe LED addresses issuing setup + load strobes.
//   clk, rst  : clock, asynchronous active-high reset
//   cmd       : command channel (eprobe_led_sequencer_if.slave)
//   abort     : stop the running sequence (only with EPROBE_SEQ_ABORT_EN)
//   led_addr  : {probe, pixel} address, stable across each strobe
//   vled      : DAC drive-strength code held for the sequence
//   en_led    : LED enable held for the sequence
//   load      : latch strobe to the pads
//   busy      : high in SETUP and LOAD
//   done      : one-cycle pulse after the last LED (or an abort)
// Optional feature macro: EPROBE_SEQ_ABORT_EN adds the abort port.
module eprobe_led_sequencer
  import eprobe_pkg::*;
#(
  parameter  int N_PROBE   = 4,
  parameter  int PIX_AW    = 8,
  parameter  int VLED_W    = 3,
  parameter  int SETUP_CYC = 1,
  parameter  int LOAD_CYC  = 1,
  localparam int AW        = $clog2(N_PROBE) + PIX_AW
) (
  input  logic              clk,
  input  logic              rst,
  eprobe_led_sequencer_if.slave cmd,
`ifdef EPROBE_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [AW-1:0]     led_addr,
  output logic [VLED_W-1:0] vled,
  output logic              en_led,
  output logic              load,
  output logic              busy,
  output logic              done
);

  localparam int            MAX_CYC  = (SETUP_CYC > LOAD_CYC) ? SETUP_CYC : LOAD_CYC;
  localparam int            CW       = cnt_width(MAX_CYC);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LOAD_LD  = CW'(LOAD_CYC - 1);
  localparam logic [AW-1:0] MAX_ADDR = '1;

  seq_state_t    state;
  logic [AW-1:0] end_addr;
  logic          ready_q;
  logic          abort_pend;
  logic          abort_in;
  logic          start_seq;
  logic          finish_now;
  logic          tmr_reload;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

`ifdef EPROBE_SEQ_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  assign cmd.cmd_ready = ready_q;

  // NOP handshakes are consumed in IDLE without starting anything.
  assign start_seq  = cmd.cmd_valid && ready_q && (state == ST_IDLE) && (cmd.cmd_op != OP_NOP);
  // An abort seen anywhere in the strobe ends the sequence once the strobe completes.
  assign finish_now = (led_addr == end_addr) || abort_in || abort_pend;

  // The timer restarts at the start of every phase: on command accept it
  // times SETUP, and at the end of each phase it times the following one.
  assign tmr_reload = start_seq || (((state == ST_SETUP) || (state == ST_LOAD)) && tmr_tc);
  assign tmr_val    = (state == ST_SETUP) ? LOAD_LD : SETUP_LD;

  eprobe_strobe_timer #(
    .MAX_CYC (MAX_CYC)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .reload     (tmr_reload),
    .reload_val (tmr_val),
    .tc         (tmr_tc)
  );

  // Sequencer FSM. Every output is a register updated alongside the state,
  // so led_addr only ever moves on the LOAD->SETUP edge while load is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      led_addr   <= '0;
      end_addr   <= '0;
      vled       <= '0;
      en_led     <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ready_q    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (start_seq) begin
            vled       <= cmd.cmd_vled;
            en_led     <= cmd.cmd_en;
            abort_pend <= 1'b0;
            case (cmd.cmd_op)
              OP_SINGLE: begin
                led_addr <= cmd.cmd_start;
                end_addr <= cmd.cmd_start;
              end
              OP_RANGE: begin
                led_addr <= cmd.cmd_start;
                end_addr <= cmd.cmd_end;
              end
              default: begin
                led_addr <= '0;
                end_addr <= MAX_ADDR;
              end
            endcase
            ready_q <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (abort_in) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (tmr_tc) begin
            load  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort_in) begin
            abort_pend <= 1'b1;
          end
          if (tmr_tc) begin
            load <= 1'b0;
            if (finish_now) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              // Wraps naturally past MAX_ADDR back to 0.
              led_addr <= led_addr + AW'(1);
              state    <= ST_SETUP;
            end
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eprobe_led_sequencer.sv
// tb_eprobe_led_sequencer: self-checking bench for eprobe_led_sequencer.
//   dut_a : default parameters (4 probes x 256 pixels, 1-cycle setup and load)
//   dut_b : SETUP_CYC=3, LOAD_CYC=2 for the multi-cycle strobe timing
// Expected per-cycle outputs come from the timing rules: LED i of a sequence
// occupies cycles i*P+1 .. (i+1)*P after the handshake (P = setup + load),
// with load high in the last LOAD_CYC of them, and done on cycle N*P+1.
module tb_eprobe_led_sequencer;
  import eprobe_pkg::*;

  localparam int AW = 10;
  localparam int S  = 1;
  localparam int L  = 1;
  localparam int P  = S + L;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  eprobe_led_sequencer_if #(.AW(AW), .VLED_W(3)) cif ();
  eprobe_led_sequencer_if #(.AW(AW), .VLED_W(3)) tif ();

  logic [AW-1:0] aAddr, bAddr;
  logic [2:0]    aVled, bVled;
  logic          aEn, aLoad, aBusy, aDone;
  logic          bEn, bLoad, bBusy, bDone;

`ifdef EPROBE_SEQ_ABORT_EN
  logic abortA = 1'b0;
  logic abortB = 1'b0;
`endif

  eprobe_led_sequencer dut_a (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cif),
`ifdef EPROBE_SEQ_ABORT_EN
    .abort    (abortA),
`endif
    .led_addr (aAddr),
    .vled     (aVled),
    .en_led   (aEn),
    .load     (aLoad),
    .busy     (aBusy),
    .done     (aDone)
  );

  eprobe_led_sequencer #(.SETUP_CYC(3), .LOAD_CYC(2)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .cmd      (tif),
`ifdef EPROBE_SEQ_ABORT_EN
    .abort    (abortB),
`endif
    .led_addr (bAddr),
    .vled     (bVled),
    .en_led   (bEn),
    .load     (bLoad),
    .busy     (bBusy),
    .done     (bDone)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] lastAddr;
  logic [2:0]    lastV;
  logic          lastE;

  typedef struct {
    logic [1:0]    op;
    logic [2:0]    v;
    logic          e;
    logic [AW-1:0] s;
    logic [AW-1:0] t;
    int            visits;
    int            doneAt;
  } vec_t;

  typedef struct {
    logic          load;
    logic          done;
    logic          busy;
    logic [AW-1:0] addr;
  } tvec_t;

  vec_t  tbl[6];
  tvec_t ttbl[12];

  // Observed DUT A state packed as {ready, busy, load, done, addr, vled, en}.
  function automatic logic [17:0] obsA();
    return {cif.cmd_ready, aBusy, aLoad, aDone, aAddr, aVled, aEn};
  endfunction

  function automatic logic [17:0] obsB();
    return {tif.cmd_ready, bBusy, bLoad, bDone, bAddr, bVled, bEn};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] v, input logic e,
                               input logic [AW-1:0] s, input logic [AW-1:0] t);
    cif.cmd_op    = op;
    cif.cmd_vled  = v;
    cif.cmd_en    = e;
    cif.cmd_start = s;
    cif.cmd_end   = t;
    cif.cmd_valid = 1'b1;
  endtask

  // Issue one command to DUT A at a negedge and check every cycle through
  // the return to IDLE. holdMode 1 keeps a NOP on the bus during the
  // sequence, holdMode 2 keeps a SINGLE at 0x1F0 (vled 2, en 0) waiting.
  task automatic runCmd(input string tag, input logic [1:0] op, input logic [2:0] v, input logic e,
                        input logic [AW-1:0] s, input logic [AW-1:0] t, input int holdMode,
                        input int expVisits, input int expDone);
    logic [AW-1:0] first, span, last;
    logic [17:0]   exp;
    logic          prevLoad;
    int            n, pulses, doneAt;
    span  = t - s;
    first = (op == OP_ALL) ? '0 : s;
    if (op == OP_SINGLE)   n = 1;
    else if (op == OP_ALL) n = 1 << AW;
    else                   n = int'(span) + 1;
    last     = first + AW'(n - 1);
    pulses   = 0;
    doneAt   = -1;
    prevLoad = 1'b0;
    applyStimulus(op, v, e, s, t);
    checkOutput({tag, "_ready"}, 32'(cif.cmd_ready), 32'd1);
    @(negedge clk);
    case (holdMode)
      1: cif.cmd_op = OP_NOP;
      2: begin
        cif.cmd_op    = OP_SINGLE;
        cif.cmd_vled  = 3'd2;
        cif.cmd_en    = 1'b0;
        cif.cmd_start = 10'h1F0;
        cif.cmd_end   = 10'h1F0;
      end
      default: cif.cmd_valid = 1'b0;
    endcase
    for (int k = 1; k <= n * P + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= n * P)
        exp = {1'b0, 1'b1, (((k - 1) % P) >= S), 1'b0, first + AW'((k - 1) / P), v, e};
      else if (k == n * P + 1)
        exp = {1'b0, 1'b0, 1'b0, 1'b1, last, v, e};
      else
        exp = {1'b1, 1'b0, 1'b0, 1'b0, last, v, e};
      checkOutput($sformatf("%s_k%0d", tag, k), 32'(obsA()), 32'(exp));
      if (aLoad && !prevLoad) pulses++;
      prevLoad = aLoad;
      if (aDone && doneAt < 0) doneAt = k;
    end
    if (expVisits >= 0) checkOutput({tag, "_visits"}, 32'(pulses), 32'(expVisits));
    if (expDone >= 0)   checkOutput({tag, "_doneAt"}, 32'(doneAt), 32'(expDone));
    lastAddr = last;
    lastV    = v;
    lastE    = e;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{OP_SINGLE, 3'd5, 1'b1, 10'h2A5, 10'h003, 1,    3};
    tbl[1] = '{OP_ALL,    3'd3, 1'b0, 10'h055, 10'h011, 1024, 2049};
    tbl[2] = '{OP_RANGE,  3'd6, 1'b1, 10'd1021, 10'd2,  6,    13};
    tbl[3] = '{OP_RANGE,  3'd1, 1'b1, 10'd7,   10'd7,   1,    3};
    tbl[4] = '{OP_RANGE,  3'd2, 1'b0, 10'd1023, 10'd0,  2,    5};
    tbl[5] = '{OP_RANGE,  3'd7, 1'b1, 10'd5,   10'd4,   1024, 2049};

    ttbl[0]  = '{1'b0, 1'b0, 1'b1, 10'd10};
    ttbl[1]  = '{1'b0, 1'b0, 1'b1, 10'd10};
    ttbl[2]  = '{1'b0, 1'b0, 1'b1, 10'd10};
    ttbl[3]  = '{1'b1, 1'b0, 1'b1, 10'd10};
    ttbl[4]  = '{1'b1, 1'b0, 1'b1, 10'd10};
    ttbl[5]  = '{1'b0, 1'b0, 1'b1, 10'd11};
    ttbl[6]  = '{1'b0, 1'b0, 1'b1, 10'd11};
    ttbl[7]  = '{1'b0, 1'b0, 1'b1, 10'd11};
    ttbl[8]  = '{1'b1, 1'b0, 1'b1, 10'd11};
    ttbl[9]  = '{1'b1, 1'b0, 1'b1, 10'd11};
    ttbl[10] = '{1'b0, 1'b1, 1'b0, 10'd11};
    ttbl[11] = '{1'b0, 1'b0, 1'b0, 10'd11};

    cif.cmd_valid = 1'b0; cif.cmd_op = OP_NOP; cif.cmd_vled = '0; cif.cmd_en = 1'b0;
    cif.cmd_start = '0;   cif.cmd_end = '0;
    tif.cmd_valid = 1'b0; tif.cmd_op = OP_NOP; tif.cmd_vled = '0; tif.cmd_en = 1'b0;
    tif.cmd_start = '0;   tif.cmd_end = '0;

    // Reset state, and cmd_ready only after the first edge out of reset.
    rst = 1'b1;
    #12;
    checkOutput("reset_a", 32'(obsA()), 32'd0);
    checkOutput("reset_b", 32'(obsB()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("ready_before_edge", 32'(cif.cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_after_edge", 32'(obsA()), 32'h20000);
    lastAddr = '0;
    lastV    = '0;
    lastE    = 1'b0;

    // Multi-cycle strobe timing on DUT B: RANGE 10..11 with setup 3, load 2.
    tif.cmd_op = OP_RANGE; tif.cmd_vled = 3'd1; tif.cmd_en = 1'b1;
    tif.cmd_start = 10'd10; tif.cmd_end = 10'd11; tif.cmd_valid = 1'b1;
    @(negedge clk);
    tif.cmd_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      checkOutput($sformatf("timing_k%0d", k), {19'd0, bLoad, bDone, bBusy, bAddr},
                  {19'd0, ttbl[k-1].load, ttbl[k-1].done, ttbl[k-1].busy, ttbl[k-1].addr});
    end
    checkOutput("timing_hold", {28'd0, bVled, bEn}, {28'd0, 3'd1, 1'b1});

    // Directed command table on DUT A.
    for (int i = 0; i < 6; i++) begin
      runCmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].v, tbl[i].e, tbl[i].s, tbl[i].t,
             0, tbl[i].visits, tbl[i].doneAt);
    end

    // Held-off commands: a NOP waiting through a sequence is consumed
    // silently, a SINGLE waiting through the next one runs afterwards.
    runCmd("holdnop", OP_RANGE, 3'd4, 1'b1, 10'd100, 10'd102, 1, 3, 7);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("nop_idle%0d", k), 32'(obsA()),
                  32'({1'b1, 1'b0, 1'b0, 1'b0, lastAddr, lastV, lastE}));
    end
    runCmd("holdsgl", OP_RANGE, 3'd5, 1'b0, 10'd300, 10'd301, 2, 2, 5);
    runCmd("queued",  OP_SINGLE, 3'd2, 1'b0, 10'h1F0, 10'h1F0, 0, 1, 3);

    // Randomised commands against the timing model.
    for (int i = 0; i < 30; i++) begin
      int            r;
      logic [2:0]    v;
      logic          e;
      logic [AW-1:0] s, t;
      r = $urandom_range(0, 9);
      v = 3'($urandom_range(0, 7));
      e = 1'($urandom_range(0, 1));
      s = AW'($urandom_range(0, 1023));
      t = s + AW'($urandom_range(0, 12));
      if (r == 0) begin
        applyStimulus(OP_NOP, v, e, s, t);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        checkOutput($sformatf("rnd%0d_nop", i), 32'(obsA()),
                    32'({1'b1, 1'b0, 1'b0, 1'b0, lastAddr, lastV, lastE}));
      end else if (r < 4) begin
        runCmd($sformatf("rnd%0d", i), OP_SINGLE, v, e, s, 10'($urandom_range(0, 1023)), 0, 1, 3);
      end else begin
        runCmd($sformatf("rnd%0d", i), OP_RANGE, v, e, s, t, 0, -1, -1);
      end
    end

`ifdef EPROBE_SEQ_ABORT_EN
    // Abort during the LOAD of address 5 in an ALL sweep.
    begin
      int pulses;
      pulses = 0;
      applyStimulus(OP_ALL, 3'd3, 1'b1, 10'd0, 10'd0);
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      for (int k = 1; k <= 12; k++) begin
        if (k > 1) @(negedge clk);
        if (aLoad) pulses++;
      end
      checkOutput("abort_in_load", 32'(obsA()), 32'({1'b0, 1'b1, 1'b1, 1'b0, 10'd5, 3'd3, 1'b1}));
      abortA = 1'b1;
      @(negedge clk);
      abortA = 1'b0;
      checkOutput("abort_done", 32'(obsA()), 32'({1'b0, 1'b0, 1'b0, 1'b1, 10'd5, 3'd3, 1'b1}));
      checkOutput("abort_pulses", 32'(pulses), 32'd6);
      @(negedge clk);
      checkOutput("abort_idle", 32'(obsA()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 10'd5, 3'd3, 1'b1}));
    end
`endif

    // Reset in the middle of a LOAD clears everything at once, no done.
    applyStimulus(OP_SINGLE, 3'd6, 1'b1, 10'd3, 10'd3);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_load", 32'(aLoad), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 32'(obsA()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst%0d", k), 32'(obsA()), 32'h20000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
